// File: rtl/t2c_maze_pkg.sv
// Shared definitions for the maze move executor: move codes, heading
// encoding, grid size and the executor state type.
package t2c_maze_pkg;

   localparam logic [2:0] MV_STOP    = 3'd0;
   localparam logic [2:0] MV_FORWARD = 3'd1;
   localparam logic [2:0] MV_LEFT    = 3'd2;
   localparam logic [2:0] MV_RIGHT   = 3'd3;
   localparam logic [2:0] MV_UTURN   = 3'd4;

   localparam logic [1:0] HEAD_N = 2'd0;
   localparam logic [1:0] HEAD_E = 2'd1;
   localparam logic [1:0] HEAD_S = 2'd2;
   localparam logic [1:0] HEAD_W = 2'd3;

   localparam int unsigned GRID_SIZE = 9;

   typedef enum logic [1:0] {
      StIdle,
      StRotate,
      StAdvance,
      StBrake
   } state_t;

   // A phase length of 0 behaves as a single cycle
   function automatic int unsigned at_least_one(input int unsigned v);
      return (v == 0) ? 1 : v;
   endfunction

endpackage

// File: rtl/t2c_pwm_gen.sv
// Free-running PWM counter; pwm_on is high for the first PWM_DUTY counts
// of every PWM_PERIOD-cycle period.
module t2c_pwm_gen #(
   parameter int unsigned PWM_PERIOD = 4,
   parameter int unsigned PWM_DUTY   = 3
) (
   input  logic clk,
   input  logic rst_n,
   output logic pwm_on
);

   localparam int unsigned PERIOD = (PWM_PERIOD == 0) ? 1 : PWM_PERIOD;
   localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

   logic [CW-1:0] pwm_cnt;

   // Count 0..PERIOD-1 and wrap
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pwm_cnt <= '0;
      end else if (pwm_cnt == LAST) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + CW'(1);
      end
   end

   // Duty at or above the period means the motors are never gated off
   assign pwm_on = (PWM_DUTY >= PERIOD) || (32'(pwm_cnt) < PWM_DUTY);

endmodule

// File: rtl/t2c_move_executor.sv
// Executes one maze move at a time: optional pivot, one-cell advance,
// brake, then reports done and the updated heading/position.
module t2c_move_executor
   import t2c_maze_pkg::*;
#(
   parameter int unsigned FWD_CYCLES   = 8,
   parameter int unsigned TURN_CYCLES  = 4,
   parameter int unsigned UTURN_CYCLES = 8,
   parameter int unsigned BRAKE_CYCLES = 2,
   parameter int unsigned PWM_PERIOD   = 4,
   parameter int unsigned PWM_DUTY     = 3,
   parameter int unsigned START_X      = 4,
   parameter int unsigned START_Y      = 8,
   parameter int unsigned EXIT_X       = 4,
   parameter int unsigned EXIT_Y       = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       move_valid,
   input  logic [2:0] move,
   output logic       move_ready,
   output logic       mot_l_en,
   output logic       mot_r_en,
   output logic       mot_l_fwd,
   output logic       mot_r_fwd,
   output logic       done,
   output logic [1:0] heading,
   output logic [3:0] pos_x,
   output logic [3:0] pos_y,
   output logic       at_exit,
   output logic       err_illegal,
   output logic       err_bounds
);

   localparam logic [15:0] FWD_LOAD   = 16'(at_least_one(FWD_CYCLES) - 1);
   localparam logic [15:0] TURN_LOAD  = 16'(at_least_one(TURN_CYCLES) - 1);
   localparam logic [15:0] UTURN_LOAD = 16'(at_least_one(UTURN_CYCLES) - 1);
   localparam logic [15:0] BRAKE_LOAD = 16'(at_least_one(BRAKE_CYCLES) - 1);
   localparam logic [3:0]  GRID_MAX   = 4'(GRID_SIZE - 1);

   state_t      state;
   logic [15:0] phase_cnt;
   logic [2:0]  cur_move;
   logic        pwm_on;
   logic        motion;
   logic [3:0]  step_x;
   logic [3:0]  step_y;
   logic        step_ok;

   t2c_pwm_gen #(
      .PWM_PERIOD(PWM_PERIOD),
      .PWM_DUTY  (PWM_DUTY)
   ) u_pwm (
      .clk   (clk),
      .rst_n (rst_n),
      .pwm_on(pwm_on)
   );

   assign at_exit    = (pos_x == 4'(EXIT_X)) && (pos_y == 4'(EXIT_Y));
   assign move_ready = (state == StIdle) && !at_exit;
   assign motion     = (state == StRotate) || (state == StAdvance);
   assign mot_l_en   = motion && pwm_on;
   assign mot_r_en   = motion && pwm_on;

   // Candidate cell one step along the current heading, and whether it is on the grid
   always_comb begin
      step_x  = pos_x;
      step_y  = pos_y;
      step_ok = 1'b1;
      unique case (heading)
         HEAD_N: if (pos_y == 4'd0) step_ok = 1'b0; else step_y = pos_y - 4'd1;
         HEAD_S: if (pos_y >= GRID_MAX) step_ok = 1'b0; else step_y = pos_y + 4'd1;
         HEAD_E: if (pos_x >= GRID_MAX) step_ok = 1'b0; else step_x = pos_x + 4'd1;
         HEAD_W: if (pos_x == 4'd0) step_ok = 1'b0; else step_x = pos_x - 4'd1;
      endcase
   end

   // Move FSM with registered heading, position, direction, done and error outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= StIdle;
         phase_cnt   <= '0;
         cur_move    <= MV_STOP;
         done        <= 1'b0;
         mot_l_fwd   <= 1'b0;
         mot_r_fwd   <= 1'b0;
         err_illegal <= 1'b0;
         err_bounds  <= 1'b0;
         heading     <= HEAD_N;
         pos_x       <= 4'(START_X);
         pos_y       <= 4'(START_Y);
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               if (move_valid && move_ready) begin
                  cur_move <= move;
                  case (move)
                     MV_FORWARD: begin
                        state     <= StAdvance;
                        phase_cnt <= FWD_LOAD;
                        mot_l_fwd <= 1'b1;
                        mot_r_fwd <= 1'b1;
                     end
                     MV_LEFT, MV_UTURN: begin
                        state     <= StRotate;
                        phase_cnt <= (move == MV_UTURN) ? UTURN_LOAD : TURN_LOAD;
                        mot_l_fwd <= 1'b0;
                        mot_r_fwd <= 1'b1;
                     end
                     MV_RIGHT: begin
                        state     <= StRotate;
                        phase_cnt <= TURN_LOAD;
                        mot_l_fwd <= 1'b1;
                        mot_r_fwd <= 1'b0;
                     end
                     MV_STOP: done <= 1'b1;
                     default: begin
                        done        <= 1'b1;
                        err_illegal <= 1'b1;
                     end
                  endcase
               end
            end
            StRotate: begin
               if (phase_cnt == '0) begin
                  case (cur_move)
                     MV_LEFT:  heading <= heading + 2'd3;
                     MV_RIGHT: heading <= heading + 2'd1;
                     default:  heading <= heading + 2'd2;
                  endcase
                  state     <= StAdvance;
                  phase_cnt <= FWD_LOAD;
                  mot_l_fwd <= 1'b1;
                  mot_r_fwd <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt - 16'd1;
               end
            end
            StAdvance: begin
               if (phase_cnt == '0) begin
                  if (step_ok) begin
                     pos_x <= step_x;
                     pos_y <= step_y;
                  end else begin
                     err_bounds <= 1'b1;
                  end
                  state     <= StBrake;
                  phase_cnt <= BRAKE_LOAD;
               end else begin
                  phase_cnt <= phase_cnt - 16'd1;
               end
            end
            StBrake: begin
               if (phase_cnt == '0) begin
                  state <= StIdle;
                  done  <= 1'b1;
               end else begin
                  phase_cnt <= phase_cnt - 16'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_t2c_move_executor.sv
// Self-checking bench for t2c_move_executor against a behavioural move model.
module tb_t2c_move_executor;

   localparam int FWD   = 8;
   localparam int TURN  = 4;
   localparam int UTURN = 8;
   localparam int BRAKE = 2;
   localparam int PER   = 4;
   localparam int DUTY  = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       move_valid = 1'b0;
   logic [2:0] move = 3'd0;
   logic       move_ready, mot_l_en, mot_r_en, mot_l_fwd, mot_r_fwd, done;
   logic [1:0] heading;
   logic [3:0] pos_x, pos_y;
   logic       at_exit, err_illegal, err_bounds;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_lat;
   logic [15:0] adv_pat;

   // Reference state of the robot
   int m_head, m_x, m_y;
   bit m_ill, m_bnd;

   t2c_move_executor #(
      .FWD_CYCLES(FWD), .TURN_CYCLES(TURN), .UTURN_CYCLES(UTURN), .BRAKE_CYCLES(BRAKE),
      .PWM_PERIOD(PER), .PWM_DUTY(DUTY), .START_X(4), .START_Y(8), .EXIT_X(4), .EXIT_Y(0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .move_valid(move_valid), .move(move),
      .move_ready(move_ready), .mot_l_en(mot_l_en), .mot_r_en(mot_r_en),
      .mot_l_fwd(mot_l_fwd), .mot_r_fwd(mot_r_fwd), .done(done), .heading(heading),
      .pos_x(pos_x), .pos_y(pos_y), .at_exit(at_exit), .err_illegal(err_illegal),
      .err_bounds(err_bounds)
   );

   always #5 clk = ~clk;

   // Clock edges since the last reset edge; the PWM phase follows from it
   always @(posedge clk) cyc <= !rst_n ? 0 : cyc + 1;

   task automatic model_reset();
      m_head = 0; m_x = 4; m_y = 8; m_ill = 0; m_bnd = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      move_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Issue one command at a negedge and check every cycle until its done pulse
   task automatic run_move(input logic [2:0] code, input bit noise);
      int r, f, len, nx, ny;
      bit motion, ex_after;
      logic exp_en, exp_lf, exp_rf;
      last_lat = -1;
      adv_pat = '0;
      if (m_x == 4 && m_y == 0) begin
         checks++;
         if (move_ready !== 1'b0) begin
            failures++; $display("FAIL ready_at_exit: got %b want 0", move_ready);
         end
         move = code; move_valid = 1'b1;
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({done, mot_l_en, pos_x, pos_y} !== {2'b00, 4'(m_x), 4'(m_y)}) begin
               failures++;
               $display("FAIL ignored_at_exit: done=%b en=%b pos=(%0d,%0d) want 0 0 (%0d,%0d)",
                        done, mot_l_en, pos_x, pos_y, m_x, m_y);
            end
         end
         move_valid = 1'b0;
      end else begin
         motion = (code >= 3'd1) && (code <= 3'd4);
         r   = (code == 3'd2 || code == 3'd3) ? TURN : (code == 3'd4 ? UTURN : 0);
         f   = motion ? FWD : 0;
         len = motion ? r + f + BRAKE + 1 : 1;
         if (code == 3'd2) m_head = (m_head + 3) % 4;
         if (code == 3'd3) m_head = (m_head + 1) % 4;
         if (code == 3'd4) m_head = (m_head + 2) % 4;
         if (code >= 3'd5) m_ill = 1;
         if (motion) begin
            nx = m_x + ((m_head == 1) ? 1 : (m_head == 3) ? -1 : 0);
            ny = m_y + ((m_head == 2) ? 1 : (m_head == 0) ? -1 : 0);
            if (nx < 0 || nx > 8 || ny < 0 || ny > 8) m_bnd = 1;
            else begin m_x = nx; m_y = ny; end
         end
         ex_after = (m_x == 4 && m_y == 0);
         checks++;
         if (move_ready !== 1'b1) begin
            failures++; $display("FAIL ready_before: got %b want 1", move_ready);
         end
         move = code; move_valid = 1'b1;
         for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            if (noise && c < r + f + 1) begin
               move_valid = 1'b1; move = 3'd1;
            end else begin
               move_valid = 1'b0;
            end
            exp_en = motion && (c <= r + f) && ((cyc % PER) < DUTY);
            checks++;
            if ({mot_l_en, mot_r_en} !== {exp_en, exp_en}) begin
               failures++;
               $display("FAIL enable: move=%0d cycle=%0d got %b%b want %b", code, c,
                        mot_l_en, mot_r_en, exp_en);
            end
            checks++;
            if (done !== 1'(c == len)) begin
               failures++; $display("FAIL done: move=%0d cycle=%0d got %b", code, c, done);
            end
            checks++;
            if (move_ready !== 1'(c == len && !ex_after)) begin
               failures++;
               $display("FAIL ready: move=%0d cycle=%0d got %b", code, c, move_ready);
            end
            if (motion && c <= r + f) begin
               exp_lf = (c > r) || (code == 3'd3);
               exp_rf = (c > r) || (code != 3'd3);
               checks++;
               if ({mot_l_fwd, mot_r_fwd} !== {exp_lf, exp_rf}) begin
                  failures++;
                  $display("FAIL direction: move=%0d cycle=%0d got %b%b want %b%b", code, c,
                           mot_l_fwd, mot_r_fwd, exp_lf, exp_rf);
               end
            end
            if (motion && c > r && c <= r + f) adv_pat = {adv_pat[14:0], mot_l_en};
            if (done === 1'b1 && last_lat < 0) last_lat = c;
         end
         checks++;
         if ({heading, pos_x, pos_y, err_illegal, err_bounds} !==
             {2'(m_head), 4'(m_x), 4'(m_y), m_ill, m_bnd}) begin
            failures++;
            $display("FAIL result: move=%0d got h=%0d (%0d,%0d) ill=%b bnd=%b want h=%0d (%0d,%0d) ill=%b bnd=%b",
                     code, heading, pos_x, pos_y, err_illegal, err_bounds,
                     m_head, m_x, m_y, m_ill, m_bnd);
         end
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++;
      if ({done, mot_l_en, mot_r_en, mot_l_fwd, mot_r_fwd, move_ready, at_exit} !== 7'b0000010) begin
         failures++;
         $display("FAIL reset_ctrl: got %b want 0000010",
                  {done, mot_l_en, mot_r_en, mot_l_fwd, mot_r_fwd, move_ready, at_exit});
      end
      checks++;
      if ({heading, pos_x, pos_y, err_illegal, err_bounds} !== {2'd0, 4'd4, 4'd8, 2'b00}) begin
         failures++;
         $display("FAIL reset_state: got h=%0d (%0d,%0d) ill=%b bnd=%b want 0 (4,8) 0 0",
                  heading, pos_x, pos_y, err_illegal, err_bounds);
      end
   endtask

   task automatic test_forward();
      apply_reset();
      // Accept on the edge that returns the PWM count to 0
      while (cyc % PER != PER - 1) @(negedge clk);
      run_move(3'd1, 1'b0);
      checks++;
      if (adv_pat[7:0] !== 8'b11101110) begin
         failures++; $display("FAIL fwd_pwm: got %b want 11101110", adv_pat[7:0]);
      end
      checks++;
      if (last_lat != 11) begin
         failures++; $display("FAIL fwd_latency: got %0d want 11", last_lat);
      end
      checks++;
      if ({heading, pos_x, pos_y} !== {2'd0, 4'd4, 4'd7}) begin
         failures++; $display("FAIL fwd_pos: got h=%0d (%0d,%0d) want 0 (4,7)", heading, pos_x, pos_y);
      end
   endtask

   task automatic test_left();
      apply_reset();
      run_move(3'd2, 1'b0);
      checks++;
      if (last_lat != 15 || {heading, pos_x, pos_y} !== {2'd3, 4'd3, 4'd8}) begin
         failures++;
         $display("FAIL left: got lat=%0d h=%0d (%0d,%0d) want 15 3 (3,8)",
                  last_lat, heading, pos_x, pos_y);
      end
   endtask

   task automatic test_uturn();
      apply_reset();
      run_move(3'd4, 1'b0);
      checks++;
      if (last_lat != 19 || {heading, pos_x, pos_y, err_bounds} !== {2'd2, 4'd4, 4'd8, 1'b1}) begin
         failures++;
         $display("FAIL uturn: got lat=%0d h=%0d (%0d,%0d) bnd=%b want 19 2 (4,8) 1",
                  last_lat, heading, pos_x, pos_y, err_bounds);
      end
   endtask

   task automatic test_illegal_and_ignore();
      apply_reset();
      run_move(3'd6, 1'b0);
      checks++;
      if (last_lat != 1 || err_illegal !== 1'b1) begin
         failures++;
         $display("FAIL illegal: got lat=%0d ill=%b want 1 1", last_lat, err_illegal);
      end
      run_move(3'd1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checks++;
         if ({done, mot_l_en, mot_r_en, pos_x, pos_y} !== {3'b000, 4'd4, 4'd7}) begin
            failures++;
            $display("FAIL no_queue: got done=%b en=%b%b (%0d,%0d) want 0 00 (4,7)",
                     done, mot_l_en, mot_r_en, pos_x, pos_y);
         end
      end
   endtask

   task automatic test_exit();
      apply_reset();
      for (int i = 0; i < 8; i++) run_move(3'd1, 1'b0);
      checks++;
      if ({pos_x, pos_y, at_exit, move_ready} !== {4'd4, 4'd0, 2'b10}) begin
         failures++;
         $display("FAIL exit: got (%0d,%0d) at_exit=%b ready=%b want (4,0) 1 0",
                  pos_x, pos_y, at_exit, move_ready);
      end
      run_move(3'd1, 1'b0);
   endtask

   task automatic test_reset_mid_advance();
      apply_reset();
      run_move(3'd3, 1'b0);
      move = 3'd1; move_valid = 1'b1;
      @(negedge clk);
      move_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (mot_l_fwd !== 1'b1 || mot_r_fwd !== 1'b1) begin
         failures++; $display("FAIL mid_adv_dir: got %b%b want 11", mot_l_fwd, mot_r_fwd);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if ({mot_l_en, mot_r_en, done, move_ready, heading, pos_x, pos_y} !==
          {4'b0001, 2'd0, 4'd4, 4'd8}) begin
         failures++;
         $display("FAIL mid_reset: got en=%b%b done=%b ready=%b h=%0d (%0d,%0d) want 00 0 1 0 (4,8)",
                  mot_l_en, mot_r_en, done, move_ready, heading, pos_x, pos_y);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < 24; i++) begin
         run_move(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_left();
      test_uturn();
      test_illegal_and_ignore();
      test_exit();
      test_reset_mid_advance();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
